// File: rtl/stoch_net_engine.sv
// Two-layer stochastic bitstream network with a start/busy/done run controller.
// Define STOCH_NET_ABORT_EN to add an abort input that cancels a run in progress.
module stoch_net_engine #(
  parameter int IN_SIZE    = 2,
  parameter int HID_SIZE   = 2,
  parameter int OUT_SIZE   = 1,
  parameter int DATA_W     = 8,
  parameter int STREAM_LEN = 256,
  parameter int SEED       = 25,
  localparam int NW = HID_SIZE*IN_SIZE + OUT_SIZE*HID_SIZE,
  localparam int AW = (NW > 1) ? $clog2(NW) : 1,
  localparam int CW = $clog2(STREAM_LEN+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IN_SIZE*DATA_W-1:0] in_vec,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
`ifdef STOCH_NET_ABORT_EN
  input  logic                      abort,
`endif
  output logic                      busy,
  output logic                      done,
  output logic                      out_valid,
  output logic [OUT_SIZE*CW-1:0]    out_vec
);

  localparam int NS  = IN_SIZE + NW;
  localparam int NNW = $clog2(STREAM_LEN);
  localparam int SIW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int SHW = (HID_SIZE > 1) ? $clog2(HID_SIZE) : 1;
  localparam int L2B = IN_SIZE + HID_SIZE*IN_SIZE;

  // Maximal-length feedback taps for widths 2..16.
  function automatic logic [DATA_W-1:0] lfsr_taps();
    logic [31:0] m;
    case (DATA_W)
      2:       m = 32'h0003;
      3:       m = 32'h0006;
      4:       m = 32'h000C;
      5:       m = 32'h0014;
      6:       m = 32'h0030;
      7:       m = 32'h0060;
      8:       m = 32'h00B8;
      9:       m = 32'h0110;
      10:      m = 32'h0240;
      11:      m = 32'h0500;
      12:      m = 32'h0829;
      13:      m = 32'h100D;
      14:      m = 32'h2015;
      15:      m = 32'h6000;
      default: m = 32'hD008;
    endcase
    return m[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] seed_of(input int k);
    logic [DATA_W-1:0] s;
    s = DATA_W'(SEED + 5*k);
    if (s == '0) s = DATA_W'(1);
    return s;
  endfunction

  localparam logic [DATA_W-1:0] TAPS = lfsr_taps();

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                      r_state, w_state_next;
  logic                        w_start_run, w_abort;
  logic [NNW-1:0]              r_n;
  logic [1:0]                  r_drain;
  logic [SIW-1:0]              r_sel_in;
  logic [SHW-1:0]              r_sel_h;
  logic [IN_SIZE*DATA_W-1:0]   r_in;
  logic [DATA_W-1:0]           r_w [NW];
  logic [CW-1:0]               r_cnt [OUT_SIZE];
  logic                        r_busy, r_done, r_out_valid;
  logic [OUT_SIZE*CW-1:0]      r_out_vec;

  logic [NS-1:0]               w_bits, r_s1_bits;
  logic [SIW-1:0]              r_s1_seli;
  logic [SHW-1:0]              r_s1_selh, r_s2_selh;
  logic                        r_s1_v, r_s2_v, r_s3_v;
  logic [HID_SIZE-1:0]         w_hid, r_s2_hid;
  logic [OUT_SIZE*HID_SIZE-1:0] r_s2_w2;
  logic [OUT_SIZE-1:0]         w_out, r_s3_out;

  always_comb begin
    w_state_next = r_state;
    w_start_run  = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE:  if (start) begin
                 w_state_next = S_RUN;
                 w_start_run  = 1'b1;
               end
      S_RUN:   if (r_n == NNW'(STREAM_LEN-1)) w_state_next = S_DRAIN;
      S_DRAIN: if (r_drain == 2'd2) w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
`ifdef STOCH_NET_ABORT_EN
    if (abort && (r_state == S_RUN || r_state == S_DRAIN)) begin
      w_state_next = S_IDLE;
      w_abort      = 1'b1;
    end
`endif
  end

  // busy is the registered RUN/DRAIN flag, so it trails the state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_drain     <= '0;
      r_sel_in    <= '0;
      r_sel_h     <= '0;
      r_in        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_vec   <= '0;
      for (int j = 0; j < OUT_SIZE; j++) r_cnt[j] <= '0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (r_state == S_RUN || r_state == S_DRAIN) && !w_abort;
      r_done  <= (r_state == S_DONE);
      if (w_start_run) begin
        r_in        <= in_vec;
        r_n         <= '0;
        r_sel_in    <= '0;
        r_sel_h     <= '0;
        r_out_valid <= 1'b0;
        for (int j = 0; j < OUT_SIZE; j++) r_cnt[j] <= '0;
      end else begin
        if (r_state == S_RUN) begin
          r_n      <= r_n + NNW'(1);
          r_sel_in <= (r_sel_in == SIW'(IN_SIZE-1)) ? '0 : r_sel_in + SIW'(1);
          r_sel_h  <= (r_sel_h == SHW'(HID_SIZE-1)) ? '0 : r_sel_h + SHW'(1);
        end
        if (r_s3_v && !w_abort)
          for (int j = 0; j < OUT_SIZE; j++)
            if (r_s3_out[j]) r_cnt[j] <= r_cnt[j] + CW'(1);
      end
      if (r_state == S_RUN) r_drain <= '0;
      else if (r_state == S_DRAIN) r_drain <= r_drain + 2'd1;
      if (r_state == S_DONE) begin
        r_out_valid <= 1'b1;
        for (int j = 0; j < OUT_SIZE; j++) r_out_vec[j*CW +: CW] <= r_cnt[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NW; j++) r_w[j] <= '0;
    end else if (wr_en && (r_state == S_IDLE || r_state == S_DONE) && (32'(wr_addr) < NW)) begin
      r_w[wr_addr] <= wr_data;
    end
  end

  // Source k: inputs first, then weights in address order (k = IN_SIZE + addr).
  for (genvar gi = 0; gi < NS; gi++) begin : gen_src
    logic [DATA_W-1:0] r_lfsr;
    logic [DATA_W-1:0] w_val;
    if (gi < IN_SIZE) begin : gen_in
      assign w_val = r_in[gi*DATA_W +: DATA_W];
    end else begin : gen_wt
      assign w_val = r_w[gi-IN_SIZE];
    end
    always_ff @(posedge clk) begin
      if (rst || w_start_run) r_lfsr <= seed_of(gi);
      else if (r_state == S_RUN) r_lfsr <= {r_lfsr[DATA_W-2:0], ^(r_lfsr & TAPS)};
    end
    assign w_bits[gi] = (r_lfsr <= w_val);
  end

  for (genvar gi = 0; gi < HID_SIZE; gi++) begin : gen_hid
    assign w_hid[gi] = r_s1_bits[int'(r_s1_seli)] &
                       r_s1_bits[IN_SIZE + gi*IN_SIZE + int'(r_s1_seli)];
  end

  for (genvar gi = 0; gi < OUT_SIZE; gi++) begin : gen_out
    assign w_out[gi] = r_s2_hid[int'(r_s2_selh)] & r_s2_w2[gi*HID_SIZE + int'(r_s2_selh)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s2_v    <= 1'b0;
      r_s3_v    <= 1'b0;
      r_s1_bits <= '0;
      r_s1_seli <= '0;
      r_s1_selh <= '0;
      r_s2_selh <= '0;
      r_s2_hid  <= '0;
      r_s2_w2   <= '0;
      r_s3_out  <= '0;
    end else begin
      r_s1_v    <= (r_state == S_RUN) && !w_abort;
      r_s1_bits <= w_bits;
      r_s1_seli <= r_sel_in;
      r_s1_selh <= r_sel_h;
      r_s2_v    <= r_s1_v && !w_abort;
      r_s2_hid  <= w_hid;
      r_s2_w2   <= r_s1_bits[L2B +: OUT_SIZE*HID_SIZE];
      r_s2_selh <= r_s1_selh;
      r_s3_v    <= r_s2_v && !w_abort;
      r_s3_out  <= w_out;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_out_valid;
  assign out_vec   = r_out_vec;

endmodule

// File: tb/tb_stoch_net_engine.sv
// Directed bench for stoch_net_engine: timing of the handshake and exact ones-counts.
module tb_stoch_net_engine;

  localparam int N  = 256;
  localparam int CW = 9;

  logic        clk = 1'b0;
  logic        rst, start, wr_en;
  logic [15:0] in_vec;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy, done, out_valid;
  logic [CW-1:0] out_vec;
`ifdef STOCH_NET_ABORT_EN
  logic        abort = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int c_a, c_b, c_c, c_tmp;

  always #5 clk = ~clk;

  stoch_net_engine dut (
    .clk(clk), .rst(rst), .start(start), .in_vec(in_vec),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef STOCH_NET_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .out_valid(out_valid), .out_vec(out_vec)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic write_w(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic write_all(input logic [7:0] d);
    for (int j = 0; j < 6; j++) write_w(3'(j), d);
  endtask

  // Negedge k of the loop follows the k-th rising edge after the one that samples start.
  task automatic do_run(input logic [7:0] a, input logic [7:0] b, input int exp_cnt,
                        input bit mid_wr, input string tag, output int cnt);
    int done_cyc, done_cnt, busy_bad;
    done_cyc = -1; done_cnt = 0; busy_bad = 0;
    @(negedge clk);
    in_vec = {b, a}; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_vec = ~in_vec;
    for (int k = 0; k < N + 12; k++) begin
      if (k > 0) @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (busy !== ((k >= 1) && (k <= N + 3))) busy_bad++;
      start   = (k == 20) || (k == N + 3);
      wr_en   = mid_wr && (k == 10);
      wr_addr = 3'd0;
      wr_data = 8'd0;
    end
    start = 1'b0; wr_en = 1'b0;
    check({tag, "_done_cycle"}, done_cyc, N + 4);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_window"}, busy_bad, 0);
    check({tag, "_out_valid"}, out_valid, 1);
    if (exp_cnt >= 0) check({tag, "_out_vec"}, out_vec, exp_cnt);
    $display("run %s: in={%0d,%0d} out_vec=%0d done_cycle=%0d", tag, a, b, out_vec, done_cyc);
    cnt = int'(out_vec);
  endtask

  initial begin
    int dn;
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; in_vec = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_vec", out_vec, 0);

    write_all(8'd255);
    do_run(8'd255, 8'd255, 256, 1'b0, "full", c_tmp);
    do_run(8'd0, 8'd0, 0, 1'b0, "zero_in", c_tmp);
    do_run(8'd255, 8'd0, 128, 1'b0, "half", c_tmp);

    write_w(3'd4, 8'd0);
    write_w(3'd5, 8'd0);
    do_run(8'd255, 8'd255, 0, 1'b0, "zero_l2", c_tmp);
    write_w(3'd4, 8'd255);
    write_w(3'd5, 8'd255);
    write_w(3'd6, 8'd0);
    write_w(3'd7, 8'd0);
    do_run(8'd255, 8'd255, 256, 1'b0, "oob_addr", c_tmp);

    do_run(8'd128, 8'd200, -1, 1'b0, "rep_a", c_a);
    do_run(8'd128, 8'd200, -1, 1'b1, "rep_b_wr_busy", c_b);
    do_run(8'd128, 8'd200, -1, 1'b0, "rep_c", c_c);
    check("repeat_b_eq_a", c_b, c_a);
    check("repeat_c_eq_a", c_c, c_a);

`ifdef STOCH_NET_ABORT_EN
    @(negedge clk);
    in_vec = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 50; k++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    dn = 0;
    for (int k = 0; k < N + 20; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_vec_kept", out_vec, c_c);
    do_run(8'd255, 8'd255, 256, 1'b0, "after_abort", c_tmp);
`endif

    @(negedge clk);
    in_vec = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 100; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    dn = 0;
    for (int k = 0; k < N + 20; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("rst_no_done", dn, 0);
    check("rst_out_vec", out_vec, 0);
    do_run(8'd255, 8'd255, 0, 1'b0, "after_rst", c_tmp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stoch_net_engine.md
Name: stoch_net_engine

Overview:
- Parametrised two-layer stochastic bitstream network with its own run controller, the next generation of the fixed 2-2-1 network.
- Input, hidden and output widths, stream length and data width are generics. Weights are loaded at runtime through a write port.
- A start/busy/done handshake replaces the free-running compute strobe. Each run produces exact, repeatable ones-counts per output.

Parameters:
IN_SIZE, 2, number of network inputs
HID_SIZE, 2, hidden-layer neuron count
OUT_SIZE, 1, output neuron count
DATA_W, 8, width of input and weight values
STREAM_LEN, 256, bitstream samples per run (>=2)
SEED, 25, base LFSR seed; LFSR k uses SEED+5*k, forced nonzero

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  run request, sampled in IDLE only
in_vec  in  IN_SIZE*DATA_W  input values, element i at [i*DATA_W +: DATA_W]
wr_en  in  1  weight write strobe
wr_addr  in  clog2(HID_SIZE*IN_SIZE+OUT_SIZE*HID_SIZE)  weight index
wr_data  in  DATA_W  weight value
busy  out  1  run in progress
done  out  1  one-cycle pulse, results ready
out_valid  out  1  out_vec holds a completed run
out_vec  out  OUT_SIZE*CW  ones-counts, CW=clog2(STREAM_LEN+1), element o at [o*CW +: CW]

Behaviour:
- Reset: busy=0, done=0, out_valid=0, out_vec=0, FSM=IDLE, all LFSRs=seeds. Weight registers are cleared to 0.
- Weight map:
  - Layer-1 weight (h,i) sits at address h*IN_SIZE+i.
  - Layer-2 weight (o,h) sits at address HID_SIZE*IN_SIZE + o*HID_SIZE + h.
  - Out-of-range addresses are ignored.
  - Writes are accepted only in IDLE and DONE; ignored while busy.
- Value-to-bit mapping: one maximal-length DATA_W-bit Fibonacci LFSR per source, range 1..2^DATA_W-1.
  - Bit = (lfsr <= value). Value 0 gives a constant 0; value 2^DATA_W-1 gives a constant 1.
  - Sources are IN_SIZE inputs, then HID_SIZE*IN_SIZE layer-1 weights, then OUT_SIZE*HID_SIZE layer-2 weights, indexed k in that order.
  - All LFSRs reload their seeds when the run starts, so runs are repeatable.
- Neuron function: product bits are the input bit AND the weight bit, combined by scaled addition via a deterministic round-robin mux.
  - For sample n, hidden h = x[n mod IN_SIZE] & w1[h][n mod IN_SIZE].
  - For sample n, output o = hid[n mod HID_SIZE] & w2[o][n mod HID_SIZE].
  - Select counters wrap explicitly; no power-of-two requirement.
- Pipeline: stage 1 generates bits, stage 2 is layer 1, stage 3 is layer 2, each registered. The sample index n and a valid flag travel with the data.
- FSM:
  - IDLE: on start=1, latch in_vec, reseed the LFSRs, clear the counters and out_valid, then go to RUN.
  - RUN: issue samples n=0..STREAM_LEN-1, one per cycle. Go to DRAIN after the last sample.
  - DRAIN: wait 3 cycles until the pipeline is empty, then go to DONE.
  - DONE: one cycle. Copy the counters to out_vec, pulse done=1, set out_valid=1, then return to IDLE.
- busy=1 in RUN and DRAIN.
- Latency: done is asserted exactly STREAM_LEN+4 cycles after the edge that samples start.
- Counters: one per output, CW bits, increment on each valid output bit. They cannot overflow (max STREAM_LEN).
- start while busy or in DONE is ignored, not queued.
- in_vec changes during a run have no effect.
- rst mid-run: immediate return to reset state, no done pulse, weights cleared.

Optional Feature:
STOCH_NET_ABORT_EN
- Present: adds input abort (1 bit).
  - abort=1 in RUN or DRAIN returns to IDLE next cycle with busy=0 and no done.
  - out_vec keeps its previous value and out_valid stays 0.
  - Weights are retained; abort in IDLE or DONE is ignored.
- Absent: no port; a run always completes.

Test Plan:
- All weights 255, inputs {255,255}, start -> done at cycle 260, out_vec=256, out_valid=1, busy high cycles 1..259.
- All weights 255, inputs {0,0} -> out_vec=0; same weights, layer-2 weights {0,0} with inputs 255 -> out_vec=0.
- All weights 255, inputs {255,0} -> out_vec=128 exactly (hidden bit 1 on even n only; output selects hid[n mod 2]).
- Run the same config twice -> identical out_vec both runs. wr_en during busy changing weight 0 to 0 -> no effect on the current or next result.
- Assert rst at RUN cycle 100 -> busy=0, done never pulses, weights read back as 0 (subsequent run with inputs 255 gives out_vec=0).
- With STOCH_NET_ABORT_EN, abort at cycle 50 -> busy=0 next cycle, no done, out_valid=0; a fresh start then completes with 256.
